// File: rtl/video_system_cpu_debug_host_scan_if.sv
// Command/response bundle between a debug host controller and the scan
// initiator.
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr : one scan request (IR + DR image)
//   rsp_valid/rsp_ready/rsp_dr        : captured DR read-back
//   busy                              : initiator owns a command in flight
// The master modport is the requester. The slave modport is the scan
// initiator.
interface video_system_cpu_debug_host_scan_if #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic                busy;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, busy
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, busy
  );
endinterface

// File: rtl/video_system_cpu_debug_host_scan.sv
// Host-side initiator for the CPU debug slave virtual-JTAG link.
// It takes one scan command (IR + DR image) and walks the virtual states
// UIR -> CDR -> SDR -> UDR -> RTI. In SDR it shifts the DR out on tdi, LSB
// first, and captures tdo. The captured word is returned as the response.
// In simulation and on-chip test it replaces the sld hub.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   host            : command/response interface (slave modport)
//   tck, tdi, tdo   : generated test clock, serial data out and in
//   ir_in           : instruction presented to the debug slave
//   vs_uir/vs_cdr/vs_sdr/vs_udr, jtag_state_rti : virtual-state strobes
// Build option:
//   DEBUG_HOST_IR_CACHE_EN : remember the last IR issued. A command that
//   repeats it skips UIR.
module video_system_cpu_debug_host_scan #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  video_system_cpu_debug_host_scan_if.slave host,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_W = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [CNT_W-1:0]    bit_q;
  logic                tck_q, tdi_q, busy_q, cmd_ready_q, rsp_valid_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] shift_q, cap_q, rsp_dr_q;

  logic active, div_tc, rise_pt, fall_pt, accept, skip_uir, bits_done;

  // tck runs only while a scan walks the states. It is parked low otherwise.
  assign active    = (state_q != IDLE) && (state_q != RESP);
  assign div_tc    = (div_q == DIV_W'(TCK_DIV - 1));
  assign rise_pt   = active && div_tc && !tck_q;
  assign fall_pt   = active && div_tc && tck_q;
  assign accept    = (state_q == IDLE) && host.cmd_valid && cmd_ready_q;
  assign bits_done = (bit_q == CNT_W'(DR_WIDTH));

`ifdef DEBUG_HOST_IR_CACHE_EN
  logic ir_vld_q;
  assign skip_uir = ir_vld_q && (host.cmd_ir == ir_q);
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
      ir_q        <= '0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
`ifdef DEBUG_HOST_IR_CACHE_EN
      ir_vld_q    <= 1'b0;
`endif
    end else begin
      if (active) begin
        div_q <= div_tc ? '0 : div_q + 1'b1;
        if (div_tc) tck_q <= ~tck_q;
      end else begin
        div_q <= '0;
        tck_q <= 1'b0;
      end

      // Each state spans whole tck periods. Transitions happen only at a
      // falling point, so every vs_* edge lines up with tck going low.
      case (state_q)
        IDLE: if (accept) begin
          busy_q      <= 1'b1;
          cmd_ready_q <= 1'b0;
          rti_q       <= 1'b0;
          bit_q       <= '0;
          if (skip_uir) begin
            state_q <= CDR;
            cdr_q   <= 1'b1;
          end else begin
            state_q <= UIR;
            uir_q   <= 1'b1;
            ir_q    <= host.cmd_ir;
`ifdef DEBUG_HOST_IR_CACHE_EN
            ir_vld_q <= 1'b1;
`endif
          end
        end
        UIR: if (fall_pt) begin
          state_q <= CDR;
          uir_q   <= 1'b0;
          cdr_q   <= 1'b1;
        end
        CDR: if (fall_pt) begin
          // Present bit 0 before the first rising edge of SDR.
          state_q <= SDR;
          cdr_q   <= 1'b0;
          sdr_q   <= 1'b1;
          tdi_q   <= shift_q[0];
        end
        SDR: begin
          if (rise_pt && !bits_done) bit_q <= bit_q + 1'b1;
          if (fall_pt) begin
            if (bits_done) begin
              state_q <= UDR;
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              tdi_q <= shift_q[0];
            end
          end
        end
        UDR: if (fall_pt) begin
          state_q <= RTI;
          udr_q   <= 1'b0;
          rti_q   <= 1'b1;
        end
        RTI: if (fall_pt) state_q <= RESP;
        RESP: begin
          // The first RESP cycle publishes the captured word. After that,
          // the response is held until the consumer takes it.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_dr_q    <= cap_q;
          end else if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shift and capture registers. Every scan loads or refills them
  // completely, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept)
      shift_q <= host.cmd_dr;
    else if (fall_pt && ((state_q == CDR) || ((state_q == SDR) && !bits_done)))
      shift_q <= shift_q >> 1;
    // Each tdo sample enters at the MSB, so the first sample ends up in bit 0.
    if ((state_q == SDR) && rise_pt && !bits_done)
      cap_q <= {tdo, cap_q[DR_WIDTH-1:1]};
  end

  assign tck            = tck_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_q;
  assign vs_uir         = uir_q;
  assign vs_cdr         = cdr_q;
  assign vs_sdr         = sdr_q;
  assign vs_udr         = udr_q;
  assign jtag_state_rti = rti_q;
  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_dr    = rsp_dr_q;
  assign host.busy      = busy_q;

endmodule

// File: tb/tb_video_system_cpu_debug_host_scan.sv
module tb_video_system_cpu_debug_host_scan;
  localparam int DRW  = 38;
  localparam int LAT4 = (DRW + 4) * 2 * 4 + 1;
  localparam int LAT1 = (DRW + 4) * 2 * 1 + 1;
`ifdef DEBUG_HOST_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_system_cpu_debug_host_scan_if #(.IR_WIDTH(2), .DR_WIDTH(DRW)) if4 ();
  video_system_cpu_debug_host_scan_if #(.IR_WIDTH(2), .DR_WIDTH(DRW)) if1 ();

  logic       tck4, tdi4, tdo4, uir4, cdr4, sdr4, udr4, rti4;
  logic [1:0] ir4;
  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] ir1;

  video_system_cpu_debug_host_scan #(.IR_WIDTH(2), .DR_WIDTH(DRW), .TCK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .host(if4), .tck(tck4), .tdi(tdi4), .tdo(tdo4), .ir_in(ir4),
    .vs_uir(uir4), .vs_cdr(cdr4), .vs_sdr(sdr4), .vs_udr(udr4), .jtag_state_rti(rti4));

  video_system_cpu_debug_host_scan #(.IR_WIDTH(2), .DR_WIDTH(DRW), .TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .host(if1), .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir1),
    .vs_uir(uir1), .vs_cdr(cdr1), .vs_sdr(sdr1), .vs_udr(udr1), .jtag_state_rti(rti1));

  // Loop-back slave models. Each shifts tdi into its MSB on every tck rise in
  // SDR. tdo is its LSB. The models also keep running event counters.
  logic [DRW-1:0] sreg4, pre4, sreg1, pre1;
  logic load4 = 1'b0, load1 = 1'b0, tckp4 = 1'b0, tckp1 = 1'b0, uird4 = 1'b0, uird1 = 1'b0;
  int rise4 = 0, sdrc4 = 0, uirp4 = 0, rspc4 = 0;
  int rise1 = 0, sdrc1 = 0, uirp1 = 0;
  assign tdo4 = sreg4[0];
  assign tdo1 = sreg1[0];

  always @(posedge clk) begin
    tckp4 <= tck4;
    uird4 <= uir4;
    if (sdr4) sdrc4 <= sdrc4 + 1;
    if (uir4 && !uird4) uirp4 <= uirp4 + 1;
    if (if4.rsp_valid) rspc4 <= rspc4 + 1;
    if (load4) sreg4 <= pre4;
    else if (sdr4 && tck4 && !tckp4) begin
      sreg4 <= {tdi4, sreg4[DRW-1:1]};
      rise4 <= rise4 + 1;
    end
  end

  always @(posedge clk) begin
    tckp1 <= tck1;
    uird1 <= uir1;
    if (sdr1) sdrc1 <= sdrc1 + 1;
    if (uir1 && !uird1) uirp1 <= uirp1 + 1;
    if (load1) sreg1 <= pre1;
    else if (sdr1 && tck1 && !tckp1) begin
      sreg1 <= {tdi1, sreg1[DRW-1:1]};
      rise1 <= rise1 + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]     ir;
    logic [DRW-1:0] dr;
    logic [DRW-1:0] pre;
  } vec_t;

  typedef struct {
    logic [DRW-1:0] rsp;
    logic [DRW-1:0] slv;
    int             lat;
    int             uir;
  } exp_t;

  exp_t sbq[$];
  logic [1:0] last_ir4 = 2'b00;
  bit         last_v4  = 1'b0;

  // One scan on the TCK_DIV=4 instance. While the response waits, rsp_ready
  // is held low for 'hold' cycles, with a competing command applied.
  task automatic scan4(input logic [1:0] ir, input logic [DRW-1:0] dr, input logic [DRW-1:0] pre,
                       input int hold, input string tag);
    exp_t e;
    int lat, r0, s0, u0;
    bit skip;
    logic [DRW-1:0] held;
    @(negedge clk);
    pre4 = pre;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    skip  = CACHE && last_v4 && (last_ir4 == ir);
    e.rsp = pre;
    e.slv = dr;
    e.lat = skip ? LAT4 - 8 : LAT4;
    e.uir = skip ? 0 : 1;
    r0 = rise4; s0 = sdrc4; u0 = uirp4;
    if4.cmd_ir = ir;
    if4.cmd_dr = dr;
    if4.cmd_valid = 1'b1;
    @(negedge clk);
    if4.cmd_valid = 1'b0;
    sbq.push_back(e);
    last_ir4 = ir;
    last_v4  = 1'b1;
    chk({tag, " busy_after_accept"}, 64'(if4.busy), 64'(1));
    lat = 0;
    while (!if4.rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " rsp_dr"}, 64'(if4.rsp_dr), 64'(e.rsp));
    chk({tag, " tdi_stream"}, 64'(sreg4), 64'(e.slv));
    chk({tag, " sdr_rises"}, 64'(rise4 - r0), 64'(DRW));
    chk({tag, " sdr_clks"}, 64'(sdrc4 - s0), 64'(DRW * 8));
    chk({tag, " uir_pulses"}, 64'(uirp4 - u0), 64'(e.uir));
    chk({tag, " ir_in"}, 64'(ir4), 64'(ir));
    held = if4.rsp_dr;
    if (hold > 0) begin
      if4.cmd_ir = ~ir;
      if4.cmd_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({tag, " hold_state"}, 64'({if4.rsp_valid, if4.cmd_ready, if4.busy, uir4}), 64'(4'b1010));
        chk({tag, " hold_rsp_dr"}, 64'(if4.rsp_dr), 64'(held));
      end
      if4.cmd_valid = 1'b0;
    end
    if4.rsp_ready = 1'b1;
    @(negedge clk);
    if4.rsp_ready = 1'b0;
    chk({tag, " after_handshake"}, 64'({if4.rsp_valid, if4.busy, if4.cmd_ready}), 64'(3'b001));
  endtask

  vec_t tbl [5];
  int n;
  int r0, v0, s0, u0, lat;

  initial begin
    tbl[0] = '{ir: 2'b01, dr: 38'h2A_5A5A_5A5A, pre: 38'h15_1234_5678};
    tbl[1] = '{ir: 2'b11, dr: 38'h3F_FFFF_FFFF, pre: 38'h00_0000_0000};
    tbl[2] = '{ir: 2'b00, dr: 38'h00_0000_0000, pre: 38'h3F_FFFF_FFFF};
    tbl[3] = '{ir: 2'b01, dr: 38'h20_0000_0001, pre: 38'h20_0000_0001};
    tbl[4] = '{ir: 2'b11, dr: 38'h12_3456_789A, pre: 38'h2B_CDEF_0123};

    if4.cmd_valid = 1'b0; if4.cmd_ir = '0; if4.cmd_dr = '0; if4.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_ir = '0; if1.cmd_dr = '0; if1.rsp_ready = 1'b0;
    pre4 = '0; pre1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs4", 64'({tck4, tdi4, ir4, uir4, cdr4, sdr4, udr4, rti4}), 64'(9'b000000001));
    chk("reset_host4", 64'({if4.cmd_ready, if4.rsp_valid, if4.busy, if4.rsp_dr}), 64'({3'b100, 38'h0}));
    chk("reset_outputs1", 64'({tck1, uir1, cdr1, sdr1, udr1, rti1, if1.cmd_ready}), 64'(7'b0000011));
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of SDR: the scan aborts and produces no response.
    pre4 = 38'h0A_AAAA_AAAA;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    r0 = rise4;
    if4.cmd_ir = 2'b01;
    if4.cmd_dr = 38'h15_5555_5555;
    if4.cmd_valid = 1'b1;
    @(negedge clk);
    if4.cmd_valid = 1'b0;
    n = 0;
    while ((rise4 - r0) < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("midscan_reached_bit10", 64'(sdr4), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_reset_jtag", 64'({tck4, tdi4, ir4, uir4, cdr4, sdr4, udr4, rti4}), 64'(9'b000000001));
    chk("midscan_reset_host", 64'({if4.cmd_ready, if4.rsp_valid, if4.busy}), 64'(3'b100));
    reset = 1'b0;
    last_v4 = 1'b0;
    v0 = rspc4;
    repeat (400) @(negedge clk);
    chk("midscan_no_response", 64'(rspc4 - v0), 64'(0));
    chk("midscan_idle", 64'({tck4, rti4, if4.cmd_ready}), 64'(3'b011));

    for (int i = 0; i < 5; i++)
      scan4(tbl[i].ir, tbl[i].dr, tbl[i].pre, 0, $sformatf("vec%0d", i));

    // Response held off for 20 cycles while a second command is offered.
    scan4(2'b00, 38'h31_0F0F_F0F0, 38'h0C_C3C3_3C3C, 20, "hold");

    // Back-to-back scans with the same IR.
    scan4(2'b10, 38'h01_2345_6789, 38'h3E_DCBA_9876, 0, "same_ir_a");
    scan4(2'b10, 38'h22_2222_2222, 38'h11_1111_1111, 0, "same_ir_b");

    // TCK_DIV=1 instance: tck toggles every clock.
    pre1 = 38'h20_0000_0001;
    load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    r0 = rise1; s0 = sdrc1; u0 = uirp1;
    if1.cmd_ir = 2'b01;
    if1.cmd_dr = 38'h25_5555_AAAA;
    if1.cmd_valid = 1'b1;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    lat = 0;
    while (!if1.rsp_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("div1 latency", 64'(lat), 64'(LAT1));
    chk("div1 rsp_dr", 64'(if1.rsp_dr), 64'(38'h20_0000_0001));
    chk("div1 tdi_stream", 64'(sreg1), 64'(38'h25_5555_AAAA));
    chk("div1 sdr_rises", 64'(rise1 - r0), 64'(DRW));
    chk("div1 sdr_clks", 64'(sdrc1 - s0), 64'(DRW * 2));
    chk("div1 uir_pulses", 64'(uirp1 - u0), 64'(1));
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk("div1 after_handshake", 64'({if1.rsp_valid, if1.busy, if1.cmd_ready}), 64'(3'b001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
